// File: rtl/run_monitor_pkg.sv
// Shared types and default constants for the run controller / write-bus monitor.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2,
        StTmo  = 2'd3
    } run_state_e;

    localparam logic [31:0] DefHaltAddr  = 32'h0000_00FC;
    localparam logic [31:0] DefPassValue = 32'd1;

    // Terminal states hold until clear or reset.
    function automatic logic is_terminal(input run_state_e st);
        return (st == StHalt) || (st == StTmo);
    endfunction

endpackage

// File: rtl/write_log_ring.sv
// Ring buffer of data-memory writes; index 0 of the read port is always the oldest held entry.
module write_log_ring #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [AddrW-1:0]         wr_addr_i,
    input  logic [DataW-1:0]         wr_data_i,
    input  logic [$clog2(Depth)-1:0] rd_idx_i,
    output logic [AddrW-1:0]         rd_addr_o,
    output logic [DataW-1:0]         rd_data_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(Depth);

    logic [AddrW-1:0] addr_mem_q [Depth];
    logic [DataW-1:0] data_mem_q [Depth];

    logic [IdxW-1:0] head_q, head_d;
    logic [IdxW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            do_write;
    logic [IdxW-1:0] rd_slot;

    assign do_write = wr_en_i && !clear_i;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (wr_en_i) begin
            tail_d = tail_q + IdxW'(1);
            // A full buffer drops its oldest entry to make room.
            if (count_q == CountFull) begin
                head_d     = head_q + IdxW'(1);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (do_write) begin
            addr_mem_q[tail_q] <= wr_addr_i;
            data_mem_q[tail_q] <= wr_data_i;
        end
    end

    // Power-of-two depth makes the modulo a natural pointer wrap.
    assign rd_slot    = head_q + rd_idx_i;
    assign rd_addr_o  = addr_mem_q[rd_slot];
    assign rd_data_o  = data_mem_q[rd_slot];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/run_monitor.sv
// Run controller and data-memory write monitor: starts a run, counts cycles, logs writes,
// and ends on a halt-mailbox write (pass/fail by value) or on a cycle timeout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned          ADDR_W         = 32,
    parameter int unsigned          DATA_W         = 32,
    parameter int unsigned          LOG_DEPTH      = 16,
    parameter int unsigned          TIMEOUT_CYCLES = 50,
    parameter logic [ADDR_W-1:0]    HALT_ADDR      = ADDR_W'(DefHaltAddr),
    parameter logic [DATA_W-1:0]    PASS_VALUE     = DATA_W'(DefPassValue)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run_en,
    input  logic                         clear,
    input  logic                         write_enable,
    input  logic [ADDR_W-1:0]            address_to_mem,
    input  logic [DATA_W-1:0]            data_to_mem,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [ADDR_W-1:0]            log_rd_addr,
    output logic [DATA_W-1:0]            log_rd_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         overflow,
    output logic [31:0]                  cycle_count,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    run_state_e  state_q, state_d;
    logic [31:0] cycle_q, cycle_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        halt_hit;
    logic        log_wr;

    assign halt_hit = write_enable && (address_to_mem == HALT_ADDR);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        log_wr    = 1'b0;
        if (clear) begin
            state_d   = StIdle;
            cycle_d   = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cycle_d = '0;
                    if (run_en) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    log_wr = write_enable && !halt_hit;
                    // Halt write beats a coincident timeout; the counter freezes on the final edge.
                    if (halt_hit) begin
                        state_d = StHalt;
                        done_d  = 1'b1;
                        pass_d  = (data_to_mem == PASS_VALUE);
                    end else if (cycle_q == TimeoutLast) begin
                        state_d   = StTmo;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        cycle_d = cycle_q + 32'd1;
                    end
                end
                StHalt, StTmo: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cycle_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    write_log_ring #(
        .AddrW (ADDR_W),
        .DataW (DATA_W),
        .Depth (LOG_DEPTH)
    ) u_log (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (clear),
        .wr_en_i    (log_wr),
        .wr_addr_i  (address_to_mem),
        .wr_data_i  (data_to_mem),
        .rd_idx_i   (log_rd_idx),
        .rd_addr_o  (log_rd_addr),
        .rd_data_o  (log_rd_data),
        .count_o    (log_count),
        .overflow_o (overflow)
    );

    assign cycle_count = cycle_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: queue-based model compared every cycle, plus literal checks.
module tb_run_monitor;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam int          TMO   = 50;
    localparam logic [31:0] HALT  = 32'h0000_00FC;

    logic          clk;
    logic          reset;
    logic          run_en;
    logic          clear;
    logic          write_enable;
    logic [AW-1:0] address_to_mem;
    logic [DW-1:0] data_to_mem;
    logic [3:0]    log_rd_idx;
    logic [AW-1:0] log_rd_addr;
    logic [DW-1:0] log_rd_data;
    logic [4:0]    log_count;
    logic          overflow;
    logic [31:0]   cycle_count;
    logic          done;
    logic          pass;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    run_monitor #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .LOG_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .HALT_ADDR      (HALT),
        .PASS_VALUE     (32'd1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run_en         (run_en),
        .clear          (clear),
        .write_enable   (write_enable),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .log_rd_idx     (log_rd_idx),
        .log_rd_addr    (log_rd_addr),
        .log_rd_data    (log_rd_data),
        .log_count      (log_count),
        .overflow       (overflow),
        .cycle_count    (cycle_count),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run flag, terminal flags and a bounded queue of {addr,data}.
    logic [63:0] mq[$];
    bit          m_run  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_pass = 1'b0;
    bit          m_tmo  = 1'b0;
    bit          m_ovf  = 1'b0;
    int unsigned m_cyc  = 0;

    task automatic model_reset();
        mq.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_pass = 1'b0;
        m_tmo  = 1'b0;
        m_ovf  = 1'b0;
        m_cyc  = 0;
    endtask

    task automatic model_step();
        if (!reset || clear) begin
            model_reset();
        end else if (m_run) begin
            if (write_enable && address_to_mem == HALT) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_pass = (data_to_mem == 32'd1);
            end else begin
                if (write_enable) begin
                    if (mq.size() == DEPTH) begin
                        void'(mq.pop_front());
                        m_ovf = 1'b1;
                    end
                    mq.push_back({address_to_mem, data_to_mem});
                end
                if (m_cyc == TMO - 1) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_tmo  = 1'b1;
                end else begin
                    m_cyc++;
                end
            end
        end else if (!m_done) begin
            m_cyc = 0;
            if (run_en) m_run = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    task automatic compare_all();
        logic [63:0] e;
        check("done", 64'(done), 64'(m_done));
        check("pass", 64'(pass), 64'(m_pass));
        check("timeout", 64'(timeout), 64'(m_tmo));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("log_count", 64'(log_count), 64'(mq.size()));
        if (!reset) begin
            check("log_rd_addr_rst", 64'(log_rd_addr), 64'd0);
            check("log_rd_data_rst", 64'(log_rd_data), 64'd0);
        end else if (int'(log_rd_idx) < mq.size()) begin
            e = mq[log_rd_idx];
            check("log_rd_addr", 64'(log_rd_addr), 64'(e[63:32]));
            check("log_rd_data", 64'(log_rd_data), 64'(e[31:0]));
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_all();
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        write_enable   = 1'b1;
        address_to_mem = a;
        data_to_mem    = d;
        cyc();
        write_enable = 1'b0;
    endtask

    task automatic start_run();
        run_en = 1'b1;
        cyc();
        run_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            log_rd_idx = 4'(i);
            cyc();
        end
    endtask

    initial begin
        reset          = 1'b0;
        run_en         = 1'b0;
        clear          = 1'b0;
        write_enable   = 1'b0;
        address_to_mem = '0;
        data_to_mem    = '0;
        log_rd_idx     = '0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        settle();
        check("rst_done", 64'(done), 64'd0);
        check("rst_log_count", 64'(log_count), 64'd0);
        check("rst_log_rd_addr", 64'(log_rd_addr), 64'd0);

        // Three writes then pass; a write on the run_en edge must not be logged.
        run_en         = 1'b1;
        write_enable   = 1'b1;
        address_to_mem = 32'h200;
        data_to_mem    = 32'h99;
        cyc();
        run_en       = 1'b0;
        write_enable = 1'b0;
        wr(32'h10, 32'hA);
        wr(32'h14, 32'hB);
        wr(32'h18, 32'hC);
        wr(HALT, 32'd1);
        log_rd_idx = 4'd0;
        settle();
        check("t1_done", 64'(done), 64'd1);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_log_count", 64'(log_count), 64'd3);
        check("t1_idx0_addr", 64'(log_rd_addr), 64'h10);
        check("t1_idx0_data", 64'(log_rd_data), 64'hA);
        check("t1_cycle_count", 64'(cycle_count), 64'd3);
        sweep(3);
        do_clear();
        settle();
        check("t1_clr_done", 64'(done), 64'd0);
        check("t1_clr_log_count", 64'(log_count), 64'd0);

        // Halt with a failing value.
        start_run();
        wr(HALT, 32'd7);
        settle();
        check("t2_pass", 64'(pass), 64'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_timeout", 64'(timeout), 64'd0);
        do_clear();

        // Timeout with no halt write.
        start_run();
        repeat (TMO - 1) cyc();
        settle();
        check("t3_pre_cycle", 64'(cycle_count), 64'd49);
        check("t3_pre_timeout", 64'(timeout), 64'd0);
        cyc();
        settle();
        check("t3_timeout", 64'(timeout), 64'd1);
        check("t3_done", 64'(done), 64'd1);
        check("t3_cycle", 64'(cycle_count), 64'd49);
        repeat (3) cyc();
        settle();
        check("t3_frozen_cycle", 64'(cycle_count), 64'd49);
        do_clear();

        // Ring overflow: 20 writes into 16 slots.
        start_run();
        for (int i = 0; i < 20; i++) wr(32'h100 + 32'(4 * i), 32'(i + 1));
        log_rd_idx = 4'd0;
        settle();
        check("t4_log_count", 64'(log_count), 64'd16);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_idx0_addr", 64'(log_rd_addr), 64'h110);
        check("t4_idx0_data", 64'(log_rd_data), 64'd5);
        log_rd_idx = 4'd15;
        #1;
        check("t4_idx15_addr", 64'(log_rd_addr), 64'h14C);
        check("t4_idx15_data", 64'(log_rd_data), 64'd20);
        sweep(16);
        do_clear();

        // Halt write on the final timeout cycle wins.
        start_run();
        repeat (TMO - 1) cyc();
        wr(HALT, 32'd1);
        settle();
        check("t5_done", 64'(done), 64'd1);
        check("t5_timeout", 64'(timeout), 64'd0);
        check("t5_pass", 64'(pass), 64'd1);
        check("t5_cycle", 64'(cycle_count), 64'd49);
        do_clear();
        settle();
        check("t5_clr_done", 64'(done), 64'd0);
        check("t5_clr_pass", 64'(pass), 64'd0);
        check("t5_clr_cycle", 64'(cycle_count), 64'd0);
        check("t5_clr_overflow", 64'(overflow), 64'd0);

        // Asynchronous reset mid-run.
        start_run();
        wr(32'h40, 32'h1);
        wr(32'h44, 32'h2);
        wr(32'h48, 32'h3);
        wr(32'h4C, 32'h4);
        log_rd_idx = 4'd0;
        settle();
        check("t6_pre_log_count", 64'(log_count), 64'd4);
        check("t6_pre_idx0_addr", 64'(log_rd_addr), 64'h40);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_log_count", 64'(log_count), 64'd0);
        check("t6_rst_cycle", 64'(cycle_count), 64'd0);
        check("t6_rst_addr", 64'(log_rd_addr), 64'd0);
        check("t6_rst_data", 64'(log_rd_data), 64'd0);
        cyc();
        cyc();
        reset = 1'b1;
        wr(32'h50, 32'h5);
        wr(32'h54, 32'h6);
        wr(32'h58, 32'h7);
        settle();
        check("t6_post_log_count", 64'(log_count), 64'd0);
        check("t6_post_cycle", 64'(cycle_count), 64'd0);
        check("t6_post_done", 64'(done), 64'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable, parametrised run controller and bus monitor that sits beside the processor `top` on its data-memory write bus. It starts a run and counts cycles, and it logs every data-memory write into a ring buffer. It ends the run on a write to a halt address (pass/fail by written value) or on a cycle timeout. It replaces fixed-delay stop-and-dump benches with a deterministic end-of-run status readable in simulation or on hardware.

## Interface
Parameters:
- `ADDR_W`, 32, address bus width
- `DATA_W`, 32, data bus width
- `LOG_DEPTH`, 16, write-log entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 50, maximum RUN cycles; ≥1, must fit in 32 bits
- `HALT_ADDR`, 32'h0000_00FC, halt mailbox address
- `PASS_VALUE`, 1, value written to `HALT_ADDR` meaning pass

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `run_en`  in  1  start run, sampled in IDLE
- `clear`  in  1  synchronous return to IDLE; clears all status
- `write_enable`  in  1  data-memory write strobe
- `address_to_mem`  in  ADDR_W  write address
- `data_to_mem`  in  DATA_W  write data
- `log_rd_idx`  in  $clog2(LOG_DEPTH)  log read index; 0 = oldest held entry
- `log_rd_addr`  out  ADDR_W  logged address at index
- `log_rd_data`  out  DATA_W  logged data at index
- `log_count`  out  $clog2(LOG_DEPTH)+1  valid entries, saturates at LOG_DEPTH
- `overflow`  out  1  sticky; at least one entry was overwritten
- `cycle_count`  out  32  RUN cycles elapsed
- `done`, `pass`, `timeout`  out  1 each  terminal status

## Operation
- FSM states: IDLE, RUN, HALT, TMO.
- IDLE → RUN when `run_en` = 1.
- RUN → HALT on a sampled write (`write_enable` = 1) with `address_to_mem` == `HALT_ADDR`. In the same edge, `pass` ← (`data_to_mem` == `PASS_VALUE`).
- RUN → TMO when `cycle_count` == `TIMEOUT_CYCLES`−1 and no halt write occurs that cycle.
- If a halt write and timeout coincide, the halt write wins: the FSM goes to HALT.
- HALT and TMO hold until `clear` or reset. `done` = 1 in HALT or TMO. `timeout` = 1 only in TMO.
- `clear` has priority over every other transition and works from any state.
- Logging happens only in RUN and only for writes with address ≠ `HALT_ADDR`. The halt write is not logged.
- The log is a ring buffer. A write into a full buffer overwrites the oldest entry and sets `overflow`.
- `cycle_count` increments every RUN cycle. It is frozen in HALT and TMO, and zeroed in IDLE.
- Index arithmetic is modulo LOG_DEPTH. Physical slot = (head + `log_rd_idx`) mod LOG_DEPTH, where head is the oldest entry.
- When `log_rd_idx` ≥ `log_count`, the read outputs are don't-care.

## Timing
- Reset state: IDLE. All outputs are 0: `log_count`, `overflow`, `cycle_count`, `done`, `pass`, `timeout`, and `log_rd_*`, which read zeroed storage.
- All status outputs are registered. `done` rises on the edge that samples the halt write or the final timeout cycle.
- The log read path is combinational from `log_rd_idx` to the registered storage. A logged write is readable the cycle after its edge.
- RUN is entered on the edge that samples `run_en`. A write sampled on that same edge is not logged.
- A reset assertion mid-run clears everything asynchronously. After release the block is in IDLE and needs `run_en` again.

## Structure
- Package `run_monitor_pkg` holds the state typedef (IDLE/RUN/HALT/TMO) and the default `HALT_ADDR` and `PASS_VALUE` constants.
- Sub-module `write_log_ring` contains the LOG_DEPTH×(ADDR_W+DATA_W) storage, head/tail pointers, count, overflow, and the indexed read. The top level contains the FSM, cycle counter, and halt decode.

## Test plan
- Three writes (0x10←0xA, 0x14←0xB, 0x18←0xC), then `HALT_ADDR`←1 → `done`=1, `pass`=1, `log_count`=3, idx0 = {0x10, 0xA}.
- `HALT_ADDR`←7 → `pass`=0, `done`=1, `timeout`=0.
- No halt write with `TIMEOUT_CYCLES`=50 → `timeout`=1 on the 50th RUN edge, `cycle_count`=49, frozen afterwards.
- 20 writes with `LOG_DEPTH`=16 → `log_count`=16, `overflow`=1, idx0 = 5th write, idx15 = 20th write.
- Halt write on the final timeout cycle → HALT, `timeout`=0. Then `clear` → IDLE with all status 0.
- Reset asserted mid-RUN after 4 logged writes → all outputs 0 immediately. After release, writes without `run_en` are not logged.
